// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared types and constants for the BRAM port-B arbiter
//
// Purpose: arbiter state encoding, BRAM geometry and the default burst limit.
// Ports: none (package).

package bram_pkg;

  localparam int BRAM_AW       = 9;
  localparam int BRAM_DW       = 32;
  localparam int DEF_MAX_BURST = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Maps a requester index to the state that gives it the port.
  function automatic arb_state_t own_state(input logic sel);
    return sel ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick used when the port is idle
//
// Purpose: choose which requester gets the port from IDLE.
// Ports:
//   req0, req1  : pending requests
//   last_owner  : requester that held the port most recently
//   gnt_valid   : at least one requester is pending
//   gnt_sel     : chosen requester (0 or 1), meaningful when gnt_valid=1

module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic gnt_valid,
  output logic gnt_sel
);

  assign gnt_valid = req0 | req1;
  // A lone requester wins; on a tie the one that did not own last wins.
  assign gnt_sel   = req1 & (~req0 | ~last_owner);

endmodule

// File: rtl/bram_portb_arb.sv
// rtl/bram_portb_arb.sv - two-requester arbiter driving BRAM port B
//
// Purpose: share one BRAM port between two requesters, one beat per cycle,
// bounded bursts so neither requester starves.
// Ports:
//   Clk, Reset            : clock (also clocks the BRAM) and async active-high reset
//   reqN/weN/beN/addrN/wdataN : requester N beat (held until ackN)
//   ackN                  : beat of requester N accepted this cycle (combinational)
//   rvalidN, rdata        : read return for requester N, one cycle after ackN
//   web, addrb, dinb      : BRAM port-B controls
//   doutb                 : BRAM port-B read data (one cycle latency)

module bram_portb_arb
  import bram_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int AW        = BRAM_AW
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               req0,
  input  logic               we0,
  input  logic [3:0]         be0,
  input  logic [AW-1:0]      addr0,
  input  logic [BRAM_DW-1:0] wdata0,
  input  logic               req1,
  input  logic               we1,
  input  logic [3:0]         be1,
  input  logic [AW-1:0]      addr1,
  input  logic [BRAM_DW-1:0] wdata1,
  output logic               ack0,
  output logic               ack1,
  output logic               rvalid0,
  output logic               rvalid1,
  output logic [BRAM_DW-1:0] rdata,
  output logic [3:0]         web,
  output logic [AW-1:0]      addrb,
  output logic [BRAM_DW-1:0] dinb,
  input  logic [BRAM_DW-1:0] doutb
);

  // Wide enough to hold MAX_BURST itself; the counter saturates there.
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t   state, state_next;
  logic [CW-1:0] burst_cnt, cnt_next;
  logic         last_owner, last_next;
  logic         cnt_max;
  logic         gnt_valid, gnt_sel;

  logic               accept;
  logic               sel_we;
  logic [3:0]         sel_be;
  logic [AW-1:0]      sel_addr;
  logic [BRAM_DW-1:0] sel_wdata;
  logic [AW-1:0]      addr_q;
  logic [BRAM_DW-1:0] din_q;

  rr_arb2 u_rr_arb2 (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner),
    .gnt_valid  (gnt_valid),
    .gnt_sel    (gnt_sel)
  );

  assign cnt_max = (burst_cnt == CW'(MAX_BURST));

  // State, burst counter and last owner registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= 1'b1;
    end else begin
      state      <= state_next;
      burst_cnt  <= cnt_next;
      last_owner <= last_next;
    end
  end

  // Next state and beat acceptance. Leaving an owner state always costs one
  // cycle with no beat, which is where last_owner is updated.
  always_comb begin
    state_next = state;
    cnt_next   = burst_cnt;
    last_next  = last_owner;
    ack0       = 1'b0;
    ack1       = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          state_next = own_state(gnt_sel);
          cnt_next   = '0;
        end
      end
      OWN0: begin
        if (!req0 || (cnt_max && req1)) begin
          last_next  = 1'b0;
          cnt_next   = '0;
          state_next = req1 ? OWN1 : IDLE;
        end else begin
          ack0 = 1'b1;
          if (!cnt_max) cnt_next = burst_cnt + CW'(1);
        end
      end
      OWN1: begin
        if (!req1 || (cnt_max && req0)) begin
          last_next  = 1'b1;
          cnt_next   = '0;
          state_next = req0 ? OWN0 : IDLE;
        end else begin
          ack1 = 1'b1;
          if (!cnt_max) cnt_next = burst_cnt + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath mux: the accepted requester drives the port in the same cycle.
  always_comb begin
    sel_we    = we0;
    sel_be    = be0;
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (ack1) begin
      sel_we    = we1;
      sel_be    = be1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  assign accept = ack0 | ack1;
  assign web    = (accept && sel_we) ? sel_be : 4'h0;
  assign addrb  = accept ? sel_addr  : addr_q;
  assign dinb   = accept ? sel_wdata : din_q;
  assign rdata  = doutb;

  // Address/data hold between beats and the one-cycle read return flags.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_q  <= '0;
      din_q   <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      addr_q  <= addrb;
      din_q   <= dinb;
      rvalid0 <= ack0 & ~we0;
      rvalid1 <= ack1 & ~we1;
    end
  end

endmodule

// File: tb/tb_bram_portb_arb.sv
// tb/tb_bram_portb_arb.sv - directed self-checking bench for bram_portb_arb

module tb_bram_portb_arb;

  logic        Clk   = 1'b0;
  logic        Reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [3:0]  be0 = 4'h0, be1 = 4'h0;
  logic [8:0]  addr0 = 9'h0, addr1 = 9'h0;
  logic [31:0] wdata0 = 32'h0, wdata1 = 32'h0;

  logic        ack0, ack1, rvalid0, rvalid1;
  logic [31:0] rdata, dinb, doutb;
  logic [3:0]  web;
  logic [8:0]  addrb;

  logic        b_ack0, b_ack1, b_rvalid0, b_rvalid1;
  logic [31:0] b_rdata, b_dinb;
  logic [31:0] b_doutb = 32'h0;
  logic [3:0]  b_web;
  logic [8:0]  b_addrb;

  logic [31:0] mem [0:511];

  int total = 0;
  int bad   = 0;
  int rem0, rem1, n0_before, first1, resume0, tot0, tot1, rv0, rv1, both, rv0_c17, code;
  int exp_pat [9];

  always #5 Clk = ~Clk;

  bram_portb_arb #(.MAX_BURST(16), .AW(9)) dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .we0(we0), .be0(be0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .be1(be1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb)
  );

  bram_portb_arb #(.MAX_BURST(1), .AW(9)) dut_b (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .we0(we0), .be0(be0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .be1(be1), .addr1(addr1), .wdata1(wdata1),
    .ack0(b_ack0), .ack1(b_ack1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
    .rdata(b_rdata), .web(b_web), .addrb(b_addrb), .dinb(b_dinb), .doutb(b_doutb)
  );

  // Read-first BRAM model with byte write enables.
  always @(posedge Clk) begin
    for (int i = 0; i < 4; i++)
      if (web[i]) mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
    doutb <= mem[addrb];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One beat from IDLE: request, wait for ack, drop request, check return.
  task automatic beat(input string tag, input logic who, input logic we,
                      input logic [3:0] be, input logic [8:0] a,
                      input logic [31:0] d, input logic [31:0] exp_r);
    int   n;
    logic got;
    step();
    if (!who) begin
      req0 = 1'b1; we0 = we; be0 = be; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = we; be1 = be; addr1 = a; wdata1 = d;
    end
    #2;
    n   = 0;
    got = who ? ack1 : ack0;
    while (!got && n < 8) begin
      step(); #2;
      n++;
      got = who ? ack1 : ack0;
    end
    chk({tag, "_ack"}, got, 1);
    chk({tag, "_lat"}, n, 1);
    chk({tag, "_web"}, web, we ? be : 4'h0);
    chk({tag, "_addrb"}, addrb, a);
    chk({tag, "_dinb"}, dinb, d);
    step();
    req0 = 1'b0; req1 = 1'b0;
    #2;
    chk({tag, "_rvalid"}, who ? rvalid1 : rvalid0, !we);
    if (!we) chk({tag, "_rdata"}, rdata, exp_r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_pat = '{0, 1, 0, 2, 0, 1, 0, 2, 0};

    // Reset state
    step(); step(); #2;
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_web", web, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_dinb", dinb, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    step(); Reset = 1'b0; #2;
    chk("idle_ack0", ack0, 0);

    // Single write then readback, with hold of addrb/dinb after the beat
    beat("w010", 1'b0, 1'b1, 4'hF, 9'h010, 32'hDEADBEEF, 32'h0);
    chk("hold_web", web, 0);
    chk("hold_addrb", addrb, 9'h010);
    chk("hold_dinb", dinb, 32'hDEADBEEF);
    beat("r010", 1'b0, 1'b0, 4'h0, 9'h010, 32'h0, 32'hDEADBEEF);

    // Partial byte write at the last address
    beat("w1ff", 1'b1, 1'b1, 4'hF, 9'h1FF, 32'hFFFFFFFF, 32'h0);
    beat("w1ffb", 1'b0, 1'b1, 4'h3, 9'h1FF, 32'h12345678, 32'h0);
    beat("r1ff", 1'b1, 1'b0, 4'h0, 9'h1FF, 32'h0, 32'hFFFF5678);

    // Simultaneous requests right after reset: requester 0 first
    step(); Reset = 1'b1;
    step(); step();
    Reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'h1FF;
    #2;
    chk("sim_c0_ack0", ack0, 0);
    chk("sim_c0_ack1", ack1, 0);
    step(); #2;
    chk("sim_c1_ack0", ack0, 1);
    chk("sim_c1_ack1", ack1, 0);
    step(); req0 = 1'b0; #2;
    chk("sim_c2_ack1", ack1, 0);
    chk("sim_c2_rvalid0", rvalid0, 1);
    chk("sim_c2_rdata", rdata, 32'hDEADBEEF);
    step(); #2;
    chk("sim_c3_ack1", ack1, 1);
    chk("sim_c3_addrb", addrb, 9'h1FF);
    step(); req1 = 1'b0; #2;
    chk("sim_c4_rvalid1", rvalid1, 1);
    chk("sim_c4_rdata", rdata, 32'hFFFF5678);

    // Requester 0 streams 40 reads, requester 1 joins at cycle 5 for 3 reads
    rem0 = 40; rem1 = 3; n0_before = 0; first1 = -1; resume0 = -1;
    tot0 = 0; tot1 = 0; rv0 = 0; rv1 = 0; both = 0; rv0_c17 = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      req0 = (rem0 > 0); we0 = 1'b0; addr0 = 9'(40 - rem0);
      req1 = (c >= 5) && (rem1 > 0); we1 = 1'b0; addr1 = 9'h1FF;
      #2;
      if (rvalid0) rv0++;
      if (rvalid1) rv1++;
      if (c == 17) rv0_c17 = int'(rvalid0);
      if (ack0 && ack1) both++;
      if (ack0) begin
        rem0--; tot0++;
        if (first1 < 0) n0_before++;
        else if (resume0 < 0) resume0 = c;
      end
      if (ack1) begin
        rem1--; tot1++;
        if (first1 < 0) first1 = c;
      end
    end
    chk("burst_n0_before", n0_before, 16);
    chk("burst_first1", first1, 18);
    chk("burst_tot1", tot1, 3);
    chk("burst_resume0", resume0, 22);
    chk("burst_tot0", tot0, 40);
    chk("burst_rv0", rv0, 40);
    chk("burst_rv1", rv1, 3);
    chk("burst_both", both, 0);
    chk("burst_last_rvalid", rv0_c17, 1);

    // Reset in the same cycle as an accepted read
    step(); req0 = 1'b1; we0 = 1'b0; addr0 = 9'h010; #2;
    chk("rr_idle_ack0", ack0, 0);
    step(); #2;
    chk("rr_acc_ack0", ack0, 1);
    Reset = 1'b1; #1;
    chk("rr_rst_ack0", ack0, 0);
    chk("rr_rst_web", web, 0);
    chk("rr_rst_addrb", addrb, 0);
    chk("rr_rst_dinb", dinb, 0);
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'h1FF;
    step(); #2;
    chk("rr_rvalid0", rvalid0, 0);
    chk("rr_web", web, 0);
    step(); Reset = 1'b0; #2;
    chk("rr_post_ack0", ack0, 0);
    chk("rr_post_ack1", ack1, 0);
    step(); #2;
    chk("rr_next_ack0", ack0, 1);
    chk("rr_next_ack1", ack1, 0);
    step(); req0 = 1'b0; req1 = 1'b0; #2;

    // MAX_BURST=1 instance: both requesters permanently high
    step(); Reset = 1'b1;
    step(); Reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h020; wdata0 = 32'hA5A50000;
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'h030; wdata1 = 32'h5A5A0000;
    for (int t = 0; t < 9; t++) begin
      #2;
      code = (b_ack0 && b_ack1) ? 3 : b_ack0 ? 1 : b_ack1 ? 2 : 0;
      chk($sformatf("alt%0d", t), code, exp_pat[t]);
      if (t == 1) begin
        chk("alt_addrb", b_addrb, 9'h020);
        chk("alt_dinb", b_dinb, 32'hA5A50000);
        chk("alt_web", b_web, 0);
      end
      if (t == 2) begin
        chk("alt_rvalid0", b_rvalid0, 1);
        chk("alt_rdata", b_rdata, 32'h0);
      end
      if (t == 4) chk("alt_rvalid1", b_rvalid1, 1);
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
